// File: rtl/approx_arith_pkg.sv
// Shared types, default sizes and arithmetic helpers for the approximate-adder
// error monitor and its accumulator.
package approx_arith_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_ACC_W = 32;

    // Widest operand abs_diff handles; callers zero-extend into this width.
    localparam int ABS_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ed_accumulator.sv
// Final statistics stage: folds one registered error distance per cycle into
// the sample/mismatch counters, a saturating sum and a running maximum.
module ed_accumulator
    import approx_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH:0]   ed,
    input  logic             mismatch,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed
);

    // One spare bit catches the carry that signals saturation.
    logic [ACC_W:0] sum_wide;

    assign sum_wide = {1'b0, sum_ed} + {{(ACC_W - WIDTH){1'b0}}, ed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            err_cnt    <= err_cnt + {{(CNT_W - 1){1'b0}}, mismatch};
            sum_ed     <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
            if (ed > max_ed) begin
                max_ed <= ed;
            end
        end
    end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// Result-side checker for approximate adders: recomputes the exact sum and
// gathers mismatch/error-distance statistics over a programmed run of samples.
module approx_adder_error_monitor
    import approx_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_samples_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic [WIDTH:0]   max_ed_o
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] accepted;
    logic             accept;

    logic             s1_valid;
    logic [WIDTH:0]   exact_q;
    logic [WIDTH:0]   approx_q;
    logic             s2_valid;
    logic [WIDTH:0]   ed_q;
    logic             mismatch_q;
    logic [ABS_W-1:0] ed_full;

    assign accept = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start_i wins in every state, so a run can be restarted at any time.
    always_comb begin
        next_state = state;
        if (start_i) begin
            next_state = RUN;
        end else begin
            case (state)
                IDLE:    next_state = IDLE;
                RUN:     if (accepted == target) next_state = DRAIN;
                DRAIN:   if (!s1_valid && !s2_valid) next_state = DONE;
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state == RUN) && (accepted < target);
        busy_o  = (state == RUN) || (state == DRAIN);
        done_o  = (state == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target   <= '0;
            accepted <= '0;
        end else if (start_i) begin
            target   <= num_samples_i;
            accepted <= '0;
        end else if (accept) begin
            accepted <= accepted + 1'b1;
        end
    end

    // Stage 1 captures the exact sum at full width alongside the DUT result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            exact_q  <= '0;
            approx_q <= '0;
        end else begin
            s1_valid <= accept && !start_i;
            if (accept) begin
                exact_q  <= {1'b0, add1_i} + {1'b0, add2_i};
                approx_q <= approx_i;
            end
        end
    end

    assign ed_full = abs_diff({{(ABS_W - WIDTH - 1){1'b0}}, approx_q},
                              {{(ABS_W - WIDTH - 1){1'b0}}, exact_q});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid   <= 1'b0;
            ed_q       <= '0;
            mismatch_q <= 1'b0;
        end else begin
            s2_valid <= s1_valid && !start_i;
            if (s1_valid) begin
                ed_q       <= ed_full[WIDTH:0];
                mismatch_q <= (ed_full != '0);
            end
        end
    end

    ed_accumulator #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .ACC_W(ACC_W)
    ) u_acc (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .clear      (start_i),
        .valid      (s2_valid),
        .ed         (ed_q),
        .mismatch   (mismatch_q),
        .sample_cnt (sample_cnt_o),
        .err_cnt    (err_cnt_o),
        .sum_ed     (sum_ed_o),
        .max_ed     (max_ed_o)
    );

endmodule
